// File: rtl/freelist_checkpoint_stack_pkg.sv
// Shared types and default sizes for the free-list checkpoint stack.
// Build option FLCKPT_RETIRE_MERGE_EN folds retire frees into stored snapshots.
`ifndef PHYS_REG_SZ_R10K
`define PHYS_REG_SZ_R10K 64
`endif
`ifndef BRANCH_STACK_DEPTH
`define BRANCH_STACK_DEPTH 4
`endif

package freelist_checkpoint_stack_pkg;

  localparam int unsigned branch_stack_depth = `BRANCH_STACK_DEPTH;
  localparam int unsigned phys_reg_sz        = `PHYS_REG_SZ_R10K;
  localparam int unsigned branch_tag_w       = $clog2(branch_stack_depth);

  typedef logic [branch_tag_w-1:0]       BRANCH_TAG;
  typedef logic [branch_stack_depth-1:0] BRANCH_MASK;

  typedef struct packed {
    logic                   valid;
    logic [phys_reg_sz-1:0] snap;
    BRANCH_MASK             older;
  } FL_CHECKPOINT;

endpackage

// File: rtl/flckpt_slot_alloc.sv
// Lowest-free-slot priority encoder for checkpoint allocation.
module flckpt_slot_alloc #(
  parameter int unsigned DEPTH = 4
) (
  input  logic [DEPTH-1:0]         live_mask,
  output logic [$clog2(DEPTH)-1:0] free_tag_c,
  output logic                     full_c
);

  localparam int unsigned TAG_W = $clog2(DEPTH);

  logic found_c;

  always_comb begin
    free_tag_c = '0;
    found_c    = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!found_c && !live_mask[i]) begin
        free_tag_c = TAG_W'(i);
        found_c    = 1'b1;
      end
    end
  end

  assign full_c = &live_mask;

endmodule

// File: rtl/freelist_checkpoint_stack.sv
// Free-list checkpoint stack: snapshots per in-flight branch, replayed on mispredict.
// Build option FLCKPT_RETIRE_MERGE_EN ORs retire frees into live snapshots and the restore.
module freelist_checkpoint_stack
  import freelist_checkpoint_stack_pkg::*;
#(
  parameter int unsigned DEPTH = branch_stack_depth,
  parameter int unsigned PR_SZ = phys_reg_sz
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push_valid,
  input  logic [PR_SZ-1:0]         push_free_list,
  output logic                     push_ready,
  output logic [$clog2(DEPTH)-1:0] push_tag,
  input  logic                     resolve_valid,
  input  logic [$clog2(DEPTH)-1:0] resolve_tag,
  input  logic                     resolve_mispredict,
  input  logic [PR_SZ-1:0]         retire_free_mask,
  output logic                     restore_flag,
  output logic [PR_SZ-1:0]         free_list_restore,
  output logic [DEPTH-1:0]         squash_mask,
  output logic [DEPTH-1:0]         live_mask
);

  localparam int unsigned TAG_W = $clog2(DEPTH);

  typedef struct packed {
    logic             valid;
    logic [PR_SZ-1:0] snap;
    logic [DEPTH-1:0] older;
  } slot_t;

  slot_t            slots_q [DEPTH];
  slot_t            slots_d [DEPTH];
  logic             restore_flag_q, restore_flag_d;
  logic [PR_SZ-1:0] free_list_restore_q, free_list_restore_d;
  logic [DEPTH-1:0] squash_mask_q, squash_mask_d;

  logic             full_c;
  logic [TAG_W-1:0] free_tag_c;
  logic [PR_SZ-1:0] merge_mask_c;
  logic             push_fire_c;
  logic             res_hit_c;
  logic             mispredict_c;
  logic [DEPTH-1:0] res_onehot_c;
  logic [DEPTH-1:0] kill_c;
  logic [DEPTH-1:0] clear_c;

`ifdef FLCKPT_RETIRE_MERGE_EN
  assign merge_mask_c = retire_free_mask;
`else
  logic unused_retire_c;
  assign merge_mask_c    = '0;
  assign unused_retire_c = ^retire_free_mask;
`endif

  always_comb begin
    live_mask = '0;
    for (int s = 0; s < DEPTH; s++) begin
      live_mask[s] = slots_q[s].valid;
    end
  end

  flckpt_slot_alloc #(
    .DEPTH (DEPTH)
  ) u_slot_alloc (
    .live_mask  (live_mask),
    .free_tag_c (free_tag_c),
    .full_c     (full_c)
  );

  assign push_ready  = !full_c && !(resolve_valid && resolve_mispredict);
  assign push_tag    = free_tag_c;
  assign push_fire_c = push_valid && push_ready;

  // Resolve decode: a tag naming a dead slot has no effect at all.
  always_comb begin
    res_hit_c    = resolve_valid && slots_q[resolve_tag].valid;
    mispredict_c = res_hit_c && resolve_mispredict;
    res_onehot_c = DEPTH'(1) << resolve_tag;
    kill_c       = '0;
    if (mispredict_c) begin
      kill_c = res_onehot_c;
      for (int s = 0; s < DEPTH; s++) begin
        if (slots_q[s].valid && slots_q[s].older[resolve_tag]) begin
          kill_c[s] = 1'b1;
        end
      end
    end
    if (mispredict_c) begin
      clear_c = kill_c;
    end else if (res_hit_c) begin
      clear_c = res_onehot_c;
    end else begin
      clear_c = '0;
    end
  end

  // Slot array update; a push records the start-of-cycle live set minus anything resolved now.
  always_comb begin
    for (int s = 0; s < DEPTH; s++) begin
      slots_d[s] = slots_q[s];
      if (slots_q[s].valid) begin
        slots_d[s].snap = slots_q[s].snap | merge_mask_c;
      end
      if (clear_c[s]) begin
        slots_d[s].valid = 1'b0;
      end
      slots_d[s].older = slots_q[s].older & ~clear_c;
    end
    if (push_fire_c) begin
      slots_d[free_tag_c].valid = 1'b1;
      slots_d[free_tag_c].snap  = push_free_list | merge_mask_c;
      slots_d[free_tag_c].older = live_mask & ~clear_c;
    end
  end

  always_comb begin
    restore_flag_d      = 1'b0;
    free_list_restore_d = '0;
    squash_mask_d       = '0;
    if (mispredict_c) begin
      restore_flag_d      = 1'b1;
      free_list_restore_d = slots_q[resolve_tag].snap | merge_mask_c;
      squash_mask_d       = kill_c;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < DEPTH; s++) begin
        slots_q[s] <= '0;
      end
      restore_flag_q      <= 1'b0;
      free_list_restore_q <= '0;
      squash_mask_q       <= '0;
    end else begin
      for (int s = 0; s < DEPTH; s++) begin
        slots_q[s] <= slots_d[s];
      end
      restore_flag_q      <= restore_flag_d;
      free_list_restore_q <= free_list_restore_d;
      squash_mask_q       <= squash_mask_d;
    end
  end

  assign restore_flag      = restore_flag_q;
  assign free_list_restore = free_list_restore_q;
  assign squash_mask       = squash_mask_q;

endmodule

// File: tb/tb_freelist_checkpoint_stack.sv
// Directed vector bench for freelist_checkpoint_stack (DEPTH=4, PR_SZ=16).
module tb_freelist_checkpoint_stack;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned PR_SZ = 16;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             push_valid = 1'b0;
  logic [PR_SZ-1:0] push_free_list = '0;
  logic             push_ready;
  logic [1:0]       push_tag;
  logic             resolve_valid = 1'b0;
  logic [1:0]       resolve_tag = '0;
  logic             resolve_mispredict = 1'b0;
  logic [PR_SZ-1:0] retire_free_mask = '0;
  logic             restore_flag;
  logic [PR_SZ-1:0] free_list_restore;
  logic [DEPTH-1:0] squash_mask;
  logic [DEPTH-1:0] live_mask;

  freelist_checkpoint_stack #(
    .DEPTH (DEPTH),
    .PR_SZ (PR_SZ)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .push_valid         (push_valid),
    .push_free_list     (push_free_list),
    .push_ready         (push_ready),
    .push_tag           (push_tag),
    .resolve_valid      (resolve_valid),
    .resolve_tag        (resolve_tag),
    .resolve_mispredict (resolve_mispredict),
    .retire_free_mask   (retire_free_mask),
    .restore_flag       (restore_flag),
    .free_list_restore  (free_list_restore),
    .squash_mask        (squash_mask),
    .live_mask          (live_mask)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        pv;
    logic [15:0] pfl;
    logic        rv;
    logic [1:0]  rtag;
    logic        rmis;
    logic        ready;
    logic        tag_care;
    logic [1:0]  tag;
    logic        rf;
    logic [15:0] rest;
    logic [3:0]  sq;
    logic [3:0]  live;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic pv, input logic [15:0] pfl, input logic rv,
                              input logic [1:0] rtag, input logic rmis, input logic ready,
                              input logic tag_care, input logic [1:0] tag, input logic rf,
                              input logic [15:0] rest, input logic [3:0] sq, input logic [3:0] live);
    vec_t v;
    v.pv = pv; v.pfl = pfl; v.rv = rv; v.rtag = rtag; v.rmis = rmis;
    v.ready = ready; v.tag_care = tag_care; v.tag = tag;
    v.rf = rf; v.rest = rest; v.sq = sq; v.live = live;
    return v;
  endfunction

  task automatic idle_inputs();
    push_valid = 1'b0; push_free_list = '0;
    resolve_valid = 1'b0; resolve_tag = '0; resolve_mispredict = 1'b0;
    retire_free_mask = '0;
  endtask

  logic [15:0] merge_exp;

  initial begin
    //            pv  pfl     rv rt mis  rdy care tag  rf  rest    sq       live
    vecs.push_back(mk(1, 16'h0F0, 0, 0, 0,  1, 1, 2'd0, 0, 16'h000, 4'b0000, 4'b0001));
    vecs.push_back(mk(1, 16'h0E0, 0, 0, 0,  1, 1, 2'd1, 0, 16'h000, 4'b0000, 4'b0011));
    vecs.push_back(mk(1, 16'h0C0, 0, 0, 0,  1, 1, 2'd2, 0, 16'h000, 4'b0000, 4'b0111));
    vecs.push_back(mk(1, 16'h080, 0, 0, 0,  1, 1, 2'd3, 0, 16'h000, 4'b0000, 4'b1111));
    vecs.push_back(mk(0, 16'h000, 0, 0, 0,  0, 0, 2'd0, 0, 16'h000, 4'b0000, 4'b1111));
    vecs.push_back(mk(0, 16'h000, 1, 1, 1,  0, 0, 2'd0, 1, 16'h0E0, 4'b1110, 4'b0001));
    vecs.push_back(mk(0, 16'h000, 0, 0, 0,  1, 1, 2'd1, 0, 16'h000, 4'b0000, 4'b0001));
    vecs.push_back(mk(1, 16'h0AA, 0, 0, 0,  1, 1, 2'd1, 0, 16'h000, 4'b0000, 4'b0011));
    vecs.push_back(mk(1, 16'h055, 0, 0, 0,  1, 1, 2'd2, 0, 16'h000, 4'b0000, 4'b0111));
    vecs.push_back(mk(0, 16'h000, 1, 0, 0,  1, 1, 2'd3, 0, 16'h000, 4'b0000, 4'b0110));
    vecs.push_back(mk(0, 16'h000, 1, 2, 1,  0, 0, 2'd0, 1, 16'h055, 4'b0100, 4'b0010));
    vecs.push_back(mk(0, 16'h000, 1, 2, 1,  0, 0, 2'd0, 0, 16'h000, 4'b0000, 4'b0010));
    vecs.push_back(mk(1, 16'h011, 0, 0, 0,  1, 1, 2'd0, 0, 16'h000, 4'b0000, 4'b0011));
    vecs.push_back(mk(1, 16'h022, 0, 0, 0,  1, 1, 2'd2, 0, 16'h000, 4'b0000, 4'b0111));
    vecs.push_back(mk(0, 16'h000, 1, 2, 1,  0, 0, 2'd0, 1, 16'h022, 4'b0100, 4'b0011));
    vecs.push_back(mk(0, 16'h000, 1, 0, 1,  0, 0, 2'd0, 1, 16'h011, 4'b0001, 4'b0010));
    vecs.push_back(mk(0, 16'h000, 0, 0, 0,  1, 1, 2'd0, 0, 16'h000, 4'b0000, 4'b0010));
    vecs.push_back(mk(1, 16'h101, 0, 0, 0,  1, 1, 2'd0, 0, 16'h000, 4'b0000, 4'b0011));
    vecs.push_back(mk(1, 16'h202, 0, 0, 0,  1, 1, 2'd2, 0, 16'h000, 4'b0000, 4'b0111));
    vecs.push_back(mk(1, 16'h303, 0, 0, 0,  1, 1, 2'd3, 0, 16'h000, 4'b0000, 4'b1111));
    vecs.push_back(mk(1, 16'h404, 1, 2, 0,  0, 0, 2'd0, 0, 16'h000, 4'b0000, 4'b1011));
    vecs.push_back(mk(1, 16'h404, 0, 0, 0,  1, 1, 2'd2, 0, 16'h000, 4'b0000, 4'b1111));

    idle_inputs();
    #12;
    check("reset push_ready", 32'(push_ready), 32'd1);
    check("reset push_tag", 32'(push_tag), 32'd0);
    check("reset live_mask", 32'(live_mask), 32'd0);
    check("reset restore_flag", 32'(restore_flag), 32'd0);
    check("reset free_list_restore", 32'(free_list_restore), 32'd0);
    check("reset squash_mask", 32'(squash_mask), 32'd0);
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clock);
      push_valid = vecs[i].pv; push_free_list = vecs[i].pfl;
      resolve_valid = vecs[i].rv; resolve_tag = vecs[i].rtag;
      resolve_mispredict = vecs[i].rmis;
      #1;
      check($sformatf("v%0d push_ready", i), 32'(push_ready), 32'(vecs[i].ready));
      if (vecs[i].tag_care) check($sformatf("v%0d push_tag", i), 32'(push_tag), 32'(vecs[i].tag));
      @(posedge clock);
      #1;
      check($sformatf("v%0d restore_flag", i), 32'(restore_flag), 32'(vecs[i].rf));
      check($sformatf("v%0d free_list_restore", i), 32'(free_list_restore), 32'(vecs[i].rest));
      check($sformatf("v%0d squash_mask", i), 32'(squash_mask), 32'(vecs[i].sq));
      check($sformatf("v%0d live_mask", i), 32'(live_mask), 32'(vecs[i].live));
    end

    // Reset asserted while a mispredict pulse is on the outputs.
    @(negedge clock);
    idle_inputs();
    resolve_valid = 1'b1; resolve_tag = 2'd0; resolve_mispredict = 1'b1;
    @(posedge clock);
    #1;
    check("pre-reset restore_flag", 32'(restore_flag), 32'd1);
    check("pre-reset squash_mask", 32'(squash_mask), 32'b1101);
    check("pre-reset free_list_restore", 32'(free_list_restore), 32'h101);
    #1;
    idle_inputs();
    reset = 1'b0;
    #1;
    check("async reset restore_flag", 32'(restore_flag), 32'd0);
    check("async reset free_list_restore", 32'(free_list_restore), 32'd0);
    check("async reset squash_mask", 32'(squash_mask), 32'd0);
    check("async reset live_mask", 32'(live_mask), 32'd0);
    check("async reset push_ready", 32'(push_ready), 32'd1);
    check("async reset push_tag", 32'(push_tag), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(posedge clock);
      #1;
      check($sformatf("post-reset c%0d restore_flag", c), 32'(restore_flag), 32'd0);
      check($sformatf("post-reset c%0d live_mask", c), 32'(live_mask), 32'd0);
    end

    // Retire mask arriving between push and mispredict.
`ifdef FLCKPT_RETIRE_MERGE_EN
    merge_exp = 16'h102;
`else
    merge_exp = 16'h100;
`endif
    @(negedge clock);
    push_valid = 1'b1; push_free_list = 16'h100;
    #1;
    check("merge push_tag", 32'(push_tag), 32'd0);
    @(negedge clock);
    idle_inputs();
    retire_free_mask = 16'h002;
    @(negedge clock);
    idle_inputs();
    resolve_valid = 1'b1; resolve_tag = 2'd0; resolve_mispredict = 1'b1;
    @(posedge clock);
    #1;
    check("merge restore_flag", 32'(restore_flag), 32'd1);
    check("merge free_list_restore", 32'(free_list_restore), 32'(merge_exp));
    check("merge squash_mask", 32'(squash_mask), 32'b0001);
    @(negedge clock);
    idle_inputs();
    @(posedge clock);
    #1;
    check("merge pulse end", 32'(restore_flag), 32'd0);
    check("merge live_mask", 32'(live_mask), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
